dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single-port, big-endian, byte-addressed 16-bit data memory. Port 0 serves the CPU MEM stage and port 1 the DMA/debug loader. The block uses CPU-first priority with a bounded-wait starvation guard for port 1. It issues at most one memory command per cycle and returns read data with its own valid strobe on the requesting port.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_arb_pick.sv | 24 ++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg : shared types/constants for the 16-bit data memory path    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_pkg;

  localparam int c_BUS_WIDTH = 16;
  localparam int c_PORT_CPU  = 0;
  localparam int c_PORT_DMA  = 1;

  typedef struct packed {
    logic                   we;
    logic [c_BUS_WIDTH-1:0] addr;
    logic [c_BUS_WIDTH-1:0] wdata;
  } dmem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arb_pick : CPU-first winner select with DMA starvation override |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_starve,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[c_PORT_DMA] && (i_starve || !i_req[c_PORT_CPU])) begin
      o_gnt[c_PORT_DMA] = 1'b1;
    end else if (i_req[c_PORT_CPU]) begin
      o_gnt[c_PORT_CPU] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : two-port arbiter/sequencer for the 16-bit data memory |
// | Optional alignment check: DMEM_ARB_ALIGN_CHK_EN        Rev 1.0       |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int BUS_WIDTH = c_BUS_WIDTH,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [BUS_WIDTH-1:0] p0_addr,
  input  logic [BUS_WIDTH-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [BUS_WIDTH-1:0] p0_rdata,
  output logic                 p0_err,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [BUS_WIDTH-1:0] p1_addr,
  input  logic [BUS_WIDTH-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [BUS_WIDTH-1:0] p1_rdata,
  output logic                 p1_err,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wr_data,
  input  logic [BUS_WIDTH-1:0] mem_read_data
);

  localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]           r_wait_cnt;
  logic [1:0]           r_rd_pend;
  logic [1:0]           w_req;
  logic [1:0]           w_gnt;
  logic                 w_any;
  logic                 w_we;
  logic                 w_misal;
  logic                 w_zero_rdata;
  logic [BUS_WIDTH-1:0] w_addr;
  logic [BUS_WIDTH-1:0] w_wdata;

  // Requests are masked during reset so nothing reaches the memory.
  assign w_req = {p1_req, p0_req} & {2{~rst}};

  dmem_arb_pick u_pick (
    .i_req    (w_req),
    .i_starve (r_wait_cnt == c_MAX_WAIT),
    .o_gnt    (w_gnt)
  );

  assign w_any   = |w_gnt;
  assign w_we    = w_gnt[c_PORT_DMA] ? p1_we    : p0_we;
  assign w_addr  = w_gnt[c_PORT_DMA] ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt[c_PORT_DMA] ? p1_wdata : p0_wdata;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic [1:0] r_err;
  logic       r_zero_rdata;

  assign w_misal = w_any & w_addr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err        <= 2'b00;
      r_zero_rdata <= 1'b0;
    end else begin
      r_err        <= w_gnt & {2{w_misal}};
      r_zero_rdata <= w_misal & ~w_we;
    end
  end

  assign p0_err       = r_err[c_PORT_CPU] & ~rst;
  assign p1_err       = r_err[c_PORT_DMA] & ~rst;
  assign w_zero_rdata = rst | r_zero_rdata;
`else
  assign w_misal      = 1'b0;
  assign p0_err       = 1'b0;
  assign p1_err       = 1'b0;
  assign w_zero_rdata = rst;
`endif

  assign p0_gnt      = w_gnt[c_PORT_CPU];
  assign p1_gnt      = w_gnt[c_PORT_DMA];
  assign mem_rd_en   = w_any & ~w_we & ~w_misal;
  assign mem_wr_en   = w_any &  w_we & ~w_misal;
  assign mem_addr    = w_any ? w_addr  : '0;
  assign mem_wr_data = w_any ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_rd_pend  <= 2'b00;
    end else begin
      r_rd_pend <= w_gnt & {2{~w_we}};
      if (p1_req && !w_gnt[c_PORT_DMA]) begin
        if (r_wait_cnt != c_MAX_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end
    end
  end

  // A read pending across a reset edge must never surface as rvalid.
  assign p0_rvalid = r_rd_pend[c_PORT_CPU] & ~rst;
  assign p1_rvalid = r_rd_pend[c_PORT_DMA] & ~rst;
  assign p0_rdata  = w_zero_rdata ? '0 : mem_read_data;
  assign p1_rdata  = w_zero_rdata ? '0 : mem_read_data;

endmodule
`default_nettype wire
